// File: rtl/cred_tx_pkg.sv
// Shared definitions for the secure credential transmitter.
//   state_t          frame FSM states
//   DEF_HDR_WORD     default frame header word
//   DEF_LFSR_POLY    default Galois tap mask (right-shifting)
//   DEF_ZERO_SEED    seed substituted for an all-zero session key
//   lfsr_step()      one Galois LFSR step
package cred_tx_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_CSUM,
      S_CLEAR
   } state_t;

   localparam logic [15:0] DEF_HDR_WORD  = 16'h00A5;
   localparam logic [15:0] DEF_LFSR_POLY = 16'hB400;
   localparam logic [15:0] DEF_ZERO_SEED = 16'hACE1;

   // Right-shifting Galois step: the bit shifted out selects the tap mask.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s, input logic [15:0] poly);
      return s[0] ? ((s >> 1) ^ poly) : (s >> 1);
   endfunction

endpackage

// File: rtl/keystream_lfsr.sv
// Keystream generator: 16-bit Galois LFSR.
// Ports:
//   clk, reset  clock, async active-high reset (register cleared to 0)
//   load, seed  load seed (ZERO_SUB substituted when seed is 0)
//   step        advance one step
//   clear       zeroise the register
//   ks          low KS_W bits of the register
// Priority: clear > load > step.
module keystream_lfsr
   import cred_tx_pkg::*;
#(
   parameter int          KS_W     = 8,
   parameter logic [15:0] POLY     = DEF_LFSR_POLY,
   parameter logic [15:0] ZERO_SUB = DEF_ZERO_SEED
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [15:0]     seed,
   input  logic            step,
   input  logic            clear,
   output logic [KS_W-1:0] ks
);

   logic [15:0] lfsr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         lfsr <= '0;
      else if (clear)
         lfsr <= '0;
      else if (load)
         // A zero seed would lock the LFSR at zero and send cleartext.
         lfsr <= (seed == 16'h0000) ? ZERO_SUB : seed;
      else if (step)
         lfsr <= lfsr_step(lfsr, POLY);
   end

   assign ks = lfsr[KS_W-1:0];

endmodule

// File: rtl/secure_cred_transmitter.sv
// Secure credential transmitter: frames a multi-byte credential as
// header, LFSR-masked ciphertext words and (optionally) an XOR checksum
// on a valid/ready word stream.
// Ports:
//   clk, reset          clock, async active-high reset
//   cred_in, key_in     credential (MS word first) and session key, sampled on send
//   send                start pulse; err pulses if it arrives while busy
//   busy, done, err     status
//   tx_data/valid/ready/last  output stream
// Config macro: SECURE_CRED_CSUM_EN adds the trailing checksum word.
module secure_cred_transmitter
   import cred_tx_pkg::*;
#(
   parameter int                DATA_W        = 8,
   parameter int                CRED_BYTES    = 4,
   parameter logic [DATA_W-1:0] HDR_WORD      = DATA_W'(DEF_HDR_WORD),
   parameter logic [15:0]       LFSR_POLY     = DEF_LFSR_POLY,
   parameter logic [15:0]       ZERO_SEED_SUB = DEF_ZERO_SEED
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [CRED_BYTES*DATA_W-1:0] cred_in,
   input  logic [15:0]                  key_in,
   input  logic                         send,
   output logic                         busy,
   output logic [DATA_W-1:0]            tx_data,
   output logic                         tx_valid,
   input  logic                         tx_ready,
   output logic                         tx_last,
   output logic                         done,
   output logic                         err
);

   localparam int CNT_W = (CRED_BYTES > 1) ? $clog2(CRED_BYTES) : 1;
   localparam int BUF_W = CRED_BYTES * DATA_W;

   state_t             state, state_nxt;
   logic [BUF_W-1:0]   cred_buf;
   logic [CNT_W-1:0]   word_cnt;
   logic [DATA_W-1:0]  ks;
   logic [DATA_W-1:0]  cipher;
   logic               start, data_hs, last_word;
`ifdef SECURE_CRED_CSUM_EN
   logic [DATA_W-1:0]  csum;
`endif

   assign start     = (state == S_IDLE) && send;
   assign data_hs   = (state == S_DATA) && tx_ready;
   assign last_word = (word_cnt == CNT_W'(CRED_BYTES - 1));
   // Buffer shifts left per word, so the word in flight is always on top.
   assign cipher    = cred_buf[BUF_W-1 -: DATA_W] ^ ks;

   assign busy = (state != S_IDLE);
   assign done = (state == S_CLEAR);
   assign err  = send && (state != S_IDLE);

   keystream_lfsr #(
      .KS_W     (DATA_W),
      .POLY     (LFSR_POLY),
      .ZERO_SUB (ZERO_SEED_SUB)
   ) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .load  (start),
      .seed  (key_in),
      .step  (data_hs),
      .clear (state == S_CLEAR),
      .ks    (ks)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         cred_buf <= '0;
         word_cnt <= '0;
`ifdef SECURE_CRED_CSUM_EN
         csum     <= '0;
`endif
      end else begin
         state <= state_nxt;
         if (start) begin
            cred_buf <= cred_in;
            word_cnt <= '0;
`ifdef SECURE_CRED_CSUM_EN
            csum     <= '0;
`endif
         end else if (data_hs) begin
            cred_buf <= cred_buf << DATA_W;
            word_cnt <= word_cnt + CNT_W'(1);
`ifdef SECURE_CRED_CSUM_EN
            csum     <= csum ^ cipher;
`endif
         end else if (state == S_CLEAR) begin
            cred_buf <= '0;
            word_cnt <= '0;
`ifdef SECURE_CRED_CSUM_EN
            csum     <= '0;
`endif
         end
      end
   end

   // tx_data is forced to zero whenever tx_valid is low.
   always_comb begin
      state_nxt = state;
      tx_valid  = 1'b0;
      tx_data   = '0;
      tx_last   = 1'b0;
      case (state)
         S_IDLE: if (send) state_nxt = S_HDR;
         S_HDR: begin
            tx_valid = 1'b1;
            tx_data  = HDR_WORD;
            if (tx_ready) state_nxt = S_DATA;
         end
         S_DATA: begin
            tx_valid = 1'b1;
            tx_data  = cipher;
`ifdef SECURE_CRED_CSUM_EN
            if (tx_ready && last_word) state_nxt = S_CSUM;
`else
            tx_last = last_word;
            if (tx_ready && last_word) state_nxt = S_CLEAR;
`endif
         end
`ifdef SECURE_CRED_CSUM_EN
         S_CSUM: begin
            tx_valid = 1'b1;
            tx_data  = csum;
            tx_last  = 1'b1;
            if (tx_ready) state_nxt = S_CLEAR;
         end
`endif
         S_CLEAR: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_secure_cred_transmitter.sv
// Directed bench for secure_cred_transmitter (DATA_W=8, CRED_BYTES=4).
// Expected frames are hand-computed; the checksum word is only expected
// when SECURE_CRED_CSUM_EN is defined.
module tb_secure_cred_transmitter;

`ifdef SECURE_CRED_CSUM_EN
   localparam int NW = 6;
`else
   localparam int NW = 5;
`endif
   // Frames, header first; last byte is the checksum (unused without it).
   localparam logic [47:0] FA = 48'hA5_10_22_33_44_45; // key 0001, 11223344
   localparam logic [47:0] FZ = 48'hA5_F0_52_0B_D8_71; // key 0000, 11223344
   localparam logic [47:0] FD = 48'hA5_DF_AD_BE_EF_23; // key 0001, DEADBEEF

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cred_in;
   logic [15:0] key_in;
   logic        send, tx_ready;
   logic        busy, tx_valid, tx_last, done, err;
   logic [7:0]  tx_data;

   int checks   = 0;
   int failures = 0;

   secure_cred_transmitter dut (
      .clk      (clk),
      .reset    (reset),
      .cred_in  (cred_in),
      .key_in   (key_in),
      .send     (send),
      .busy     (busy),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_last  (tx_last),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Leak check on every cycle of the run.
   always @(negedge clk)
      if (tx_valid !== 1'b1) chk("idle_data_zero", {24'h0, tx_data}, 32'h0);

   // One frame with ready high except an optional 3-cycle stall before
   // frame index stall_at; send is pulsed at frame index err_at (NW = CLEAR).
   task automatic run_frame(input logic [31:0] cred, input logic [15:0] key,
                            input logic [47:0] fr, input int stall_at, input int err_at);
      logic [7:0] exp;
      send = 1'b1; cred_in = cred; key_in = key; tx_ready = 1'b1;
      #1;
      chk("start_busy", {31'h0, busy}, 32'h0);
      chk("start_err", {31'h0, err}, 32'h0);
      chk("start_valid", {31'h0, tx_valid}, 32'h0);
      tick();
      send = 1'b0; cred_in = 32'h5A5A5A5A; key_in = 16'hFFFF;
      for (int i = 0; i < NW; i++) begin
         exp = fr[47 - 8*i -: 8];
         if (i == stall_at) begin
            tx_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               #1;
               chk("stall_data", {24'h0, tx_data}, {24'h0, exp});
               chk("stall_valid", {31'h0, tx_valid}, 32'h1);
               chk("stall_last", {31'h0, tx_last}, 32'h0);
               tick();
            end
            tx_ready = 1'b1;
         end
         if (i == err_at) send = 1'b1;
         #1;
         chk("word_data", {24'h0, tx_data}, {24'h0, exp});
         chk("word_valid", {31'h0, tx_valid}, 32'h1);
         chk("word_last", {31'h0, tx_last}, {31'h0, i == NW-1});
         chk("word_err", {31'h0, err}, {31'h0, i == err_at});
         chk("word_done", {31'h0, done}, 32'h0);
         chk("word_busy", {31'h0, busy}, 32'h1);
         tick();
         send = 1'b0;
      end
      if (err_at == NW) send = 1'b1;
      #1;
      chk("clear_done", {31'h0, done}, 32'h1);
      chk("clear_valid", {31'h0, tx_valid}, 32'h0);
      chk("clear_busy", {31'h0, busy}, 32'h1);
      chk("clear_err", {31'h0, err}, {31'h0, err_at == NW});
      tick();
      send = 1'b0;
      #1;
      chk("post_done", {31'h0, done}, 32'h0);
      chk("post_busy", {31'h0, busy}, 32'h0);
      chk("post_buf", dut.cred_buf, 32'h0);
      chk("post_lfsr", {16'h0, dut.u_lfsr.lfsr}, 32'h0);
   endtask

   initial begin
      reset = 1'b1; send = 1'b0; tx_ready = 1'b1;
      cred_in = 32'h11223344; key_in = 16'h0001;
      #3;
      chk("rst_valid", {31'h0, tx_valid}, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_buf", dut.cred_buf, 32'h0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      run_frame(32'h11223344, 16'h0001, FA, -1, -1);  // basic frame
      run_frame(32'h11223344, 16'h0000, FZ, -1, -1);  // zero key substitution
      run_frame(32'h11223344, 16'h0001, FA, 2, -1);   // stall on word 1
      run_frame(32'h11223344, 16'h0001, FA, -1, 3);   // send during DATA
      run_frame(32'h11223344, 16'h0001, FA, -1, NW);  // send during CLEAR

      // Abandon a frame mid-DATA with an asynchronous reset.
      send = 1'b1; cred_in = 32'h11223344; key_in = 16'h0001;
      tick();
      send = 1'b0;
      tick();  // header accepted
      tick();  // word 0 accepted
      #1;
      chk("mid_data", {24'h0, tx_data}, 32'h22);
      reset = 1'b1;
      #1;
      chk("arst_valid", {31'h0, tx_valid}, 32'h0);
      chk("arst_data", {24'h0, tx_data}, 32'h0);
      chk("arst_last", {31'h0, tx_last}, 32'h0);
      chk("arst_busy", {31'h0, busy}, 32'h0);
      chk("arst_done", {31'h0, done}, 32'h0);
      chk("arst_buf", dut.cred_buf, 32'h0);
      chk("arst_lfsr", {16'h0, dut.u_lfsr.lfsr}, 32'h0);
      tick();
      reset = 1'b0;
      tick();
      run_frame(32'hDEADBEEF, 16'h0001, FD, -1, -1);  // fresh frame after reset

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
